// File: rtl/lsu_mem_initiator_pkg.sv
// Shared encodings, sizes and FSM states for the LSU memory initiator.
// Consumed by lsu_align_check and lsu_mem_initiator.
package lsu_mem_initiator_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    BYTES,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_align_check.sv
// Access size decode and natural-alignment check for one request.
// Byte encodings are never misaligned; unknown encodings act as words.
module lsu_align_check
  import lsu_mem_initiator_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [2:0] size,
  output logic       misaligned
);

  always_comb begin
    size       = SIZE_W;
    misaligned = |addr_lo;
    unique case (1'b1)
      funct3 inside {FUNCT3_LB, FUNCT3_LBU}: begin
        size       = SIZE_B;
        misaligned = 1'b0;
      end
      funct3 inside {FUNCT3_LH, FUNCT3_LHU}: begin
        size       = SIZE_H;
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: aligned single access or split byte accesses.
// LSU_MISALIGNED_TRAP_EN turns misaligned requests into error responses.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DWIDTH-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

`ifdef LSU_MISALIGNED_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_t state, state_nxt;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] buf_q;
  logic [1:0]        cnt_q;
  logic [1:0]        last_q;
  logic              split_q;
  logic              err_q;

  logic [2:0] size;
  logic [1:0] last;
  logic       misaligned;
  logic       accept;
  logic [4:0] bsel;

  lsu_align_check u_align (
    .funct3     (req_funct3_i),
    .addr_lo    (req_addr_i[1:0]),
    .size       (size),
    .misaligned (misaligned)
  );

  assign last        = 2'(size - 3'd1);
  assign bsel        = {cnt_q, 3'b000};
  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!misaligned)  state_nxt = ACCESS;
          else if (TRAP_EN) state_nxt = RESP;
          else              state_nxt = BYTES;
        end
      end
      ACCESS: state_nxt = RESP;
      BYTES: if (cnt_q == last_q) state_nxt = RESP;
      RESP: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            buf_q   <= '0;
            cnt_q   <= '0;
            last_q  <= last;
            split_q <= misaligned && !TRAP_EN;
            err_q   <= misaligned && TRAP_EN;
          end
        end
        // memory already size/sign extends aligned loads
        ACCESS: buf_q <= mem_data_i;
        BYTES: begin
          if (!we_q) buf_q[bsel +: 8] <= mem_data_i[7:0];
          cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_funct3_o   = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    case (state)
      ACCESS: begin
        mem_addr_o     = addr_q;
        mem_data_o     = wdata_q;
        mem_funct3_o   = f3_q;
        mem_read_en_o  = !we_q;
        mem_write_en_o = we_q;
      end
      BYTES: begin
        mem_addr_o     = addr_q + AWIDTH'(cnt_q);
        mem_data_o     = DWIDTH'(wdata_q[bsel +: 8]);
        mem_funct3_o   = we_q ? FUNCT3_SB : FUNCT3_LBU;
        mem_read_en_o  = !we_q;
        mem_write_en_o = we_q;
      end
      default: ;
    endcase
  end

  assign resp_valid_o = (state == RESP);
  assign resp_err_o   = resp_valid_o && err_q;

  always_comb begin
    resp_rdata_o = '0;
    if (resp_valid_o && !we_q && !err_q) begin
      if (split_q && f3_q == FUNCT3_LHU)
        resp_rdata_o = {{(DWIDTH-16){1'b0}}, buf_q[15:0]};
      else if (split_q && last_q == 2'd1)
        resp_rdata_o = {{(DWIDTH-16){buf_q[15]}}, buf_q[15:0]};
      else
        resp_rdata_o = buf_q;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a byte memory model.
// Build with LSU_MISALIGNED_TRAP_EN to exercise the trap variant.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [2:0]  mem_funct3_o;
  logic [31:0] mem_data_i;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_funct3_i   (req_funct3_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_read_en_o  (mem_read_en_o),
    .mem_write_en_o (mem_write_en_o),
    .mem_funct3_o   (mem_funct3_o),
    .mem_data_i     (mem_data_i)
  );

  // 256-byte memory, aliased on addr[7:0]
  logic [7:0]  mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [7:0]  ma;
  logic [31:0] mw;
  logic [31:0] wlog [$];

  always_comb begin
    ma = mem_addr_o[7:0];
    mw = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
    mem_data_i = '0;
    if (mem_read_en_o) begin
      case (mem_funct3_o)
        3'd0:    mem_data_i = {{24{mw[7]}}, mw[7:0]};
        3'd1:    mem_data_i = {{16{mw[15]}}, mw[15:0]};
        3'd4:    mem_data_i = {24'h0, mw[7:0]};
        3'd5:    mem_data_i = {16'h0, mw[15:0]};
        default: mem_data_i = mw;
      endcase
    end
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (mem_write_en_o) begin
      wlog.push_back(mem_addr_o);
      mem[ma] <= mem_data_o[7:0];
      if (mem_funct3_o == 3'd1 || mem_funct3_o == 3'd2)
        mem[ma+8'd1] <= mem_data_o[15:8];
      if (mem_funct3_o == 3'd2) begin
        mem[ma+8'd2] <= mem_data_o[23:16];
        mem[ma+8'd3] <= mem_data_o[31:24];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [2:0]  acc_f3;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              input logic [31:0] rdata, input logic err,
                              input logic [2:0] acc_f3);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.rdata = rdata; v.err = err; v.acc_f3 = acc_f3;
    return v;
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int nacc;
    logic split;
    logic [31:0] exp_d;
    split = (v.lat > 2);
    @(posedge clk); #1;
    chk($sformatf("v%0d_ready_idle", idx), 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = v.we; req_funct3_i = v.f3;
    req_addr_i = v.addr; req_wdata_i = v.wdata;
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_we_i = ~v.we; req_funct3_i = 3'd7;
    req_addr_i = 32'h0BAD0000; req_wdata_i = ~v.wdata;
    lat = 1; nacc = 0;
    while (!resp_valid_o && lat < 16) begin
      chk($sformatf("v%0d_ready_busy", idx), 32'(req_ready_o), 32'd0);
      if (mem_read_en_o || mem_write_en_o) begin
        chk($sformatf("v%0d_acc%0d_addr", idx, nacc), mem_addr_o,
            v.addr + 32'(nacc));
        chk($sformatf("v%0d_acc%0d_f3", idx, nacc), 32'(mem_funct3_o),
            32'(v.acc_f3));
        chk($sformatf("v%0d_acc%0d_dir", idx, nacc),
            32'({mem_write_en_o, mem_read_en_o}), v.we ? 32'd2 : 32'd1);
        exp_d = split ? ((v.wdata >> (8 * nacc)) & 32'hFF) : v.wdata;
        if (v.we)
          chk($sformatf("v%0d_acc%0d_data", idx, nacc), mem_data_o, exp_d);
        nacc++;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_rdata", idx), resp_rdata_o, v.rdata);
    chk($sformatf("v%0d_err", idx), 32'(resp_err_o), 32'(v.err));
    chk($sformatf("v%0d_nacc", idx), 32'(nacc), 32'(v.lat - 1));
    chk($sformatf("v%0d_resp_noacc", idx),
        32'({mem_read_en_o, mem_write_en_o}), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_pulse_end", idx), 32'(resp_valid_o), 32'd0);
    chk($sformatf("v%0d_ready_back", idx), 32'(req_ready_o), 32'd1);
  endtask

  vec_t tbl [$];
  logic [31:0] w0, w1;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_resp", 32'({resp_valid_o, resp_err_o}), 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_en", 32'({mem_read_en_o, mem_write_en_o}), 32'd0);
    chk("rst_maddr", mem_addr_o, 32'd0);
    chk("rst_mdata", mem_data_o, 32'd0);
    chk("rst_mf3", 32'(mem_funct3_o), 32'd0);
    poke(8'h00, 8'hEF); poke(8'h01, 8'hBE);
    poke(8'h02, 8'hAD); poke(8'h03, 8'hDE);
    poke(8'h04, 8'h5A); poke(8'h05, 8'hC3);
    poke(8'h06, 8'h00); poke(8'h07, 8'h00);
    poke(8'h0C, 8'h00); poke(8'hFF, 8'h34);
    @(negedge clk) rst = 1'b1;

    // back-to-back loads with valid held high
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'd2;
    req_addr_i = 32'h01000000; req_wdata_i = '0;
    @(posedge clk); #1;
    chk("b2b_access_ready", 32'(req_ready_o), 32'd0);
    chk("b2b_access_rd", 32'(mem_read_en_o), 32'd1);
    chk("b2b_access_f3", 32'(mem_funct3_o), 32'd2);
    @(posedge clk); #1;
    chk("b2b_resp1", 32'(resp_valid_o), 32'd1);
    chk("b2b_rdata1", resp_rdata_o, 32'hDEADBEEF);
    chk("b2b_resp_ready", 32'(req_ready_o), 32'd0);
    req_addr_i = 32'h01000004;
    @(posedge clk); #1;
    chk("b2b_idle_ready", 32'(req_ready_o), 32'd1);
    chk("b2b_idle_resp", 32'(resp_valid_o), 32'd0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    chk("b2b_access2_rd", 32'(mem_read_en_o), 32'd1);
    chk("b2b_access2_addr", mem_addr_o, 32'h01000004);
    @(posedge clk); #1;
    chk("b2b_resp2", 32'(resp_valid_o), 32'd1);
    chk("b2b_rdata2", resp_rdata_o, 32'h0000C35A);
    @(posedge clk); #1;
    chk("b2b_pulse_end", 32'(resp_valid_o), 32'd0);

`ifdef LSU_MISALIGNED_TRAP_EN
    tbl.push_back(mk(0, 3'd2, 32'h01000000, 0, 2, 32'hDEADBEEF, 0, 3'd2));
    tbl.push_back(mk(0, 3'd2, 32'h01000002, 0, 1, 32'h0, 1, 3'd0));
    tbl.push_back(mk(1, 3'd2, 32'h01000001, 32'h11223344, 1, 0, 1, 3'd0));
    tbl.push_back(mk(0, 3'd2, 32'h01000000, 0, 2, 32'hDEADBEEF, 0, 3'd2));
    tbl.push_back(mk(0, 3'd1, 32'h01000001, 0, 1, 32'h0, 1, 3'd0));
    tbl.push_back(mk(0, 3'd5, 32'h01000002, 0, 2, 32'h0000DEAD, 0, 3'd5));
`else
    tbl.push_back(mk(0, 3'd2, 32'h01000000, 0, 2, 32'hDEADBEEF, 0, 3'd2));
    tbl.push_back(mk(1, 3'd2, 32'h01000001, 32'h11223344, 5, 0, 0, 3'd0));
    tbl.push_back(mk(0, 3'd2, 32'h01000000, 0, 2, 32'h223344EF, 0, 3'd2));
    tbl.push_back(mk(0, 3'd2, 32'h01000001, 0, 5, 32'h11223344, 0, 3'd4));
    tbl.push_back(mk(0, 3'd0, 32'h01000000, 0, 2, 32'hFFFFFFEF, 0, 3'd0));
    tbl.push_back(mk(0, 3'd1, 32'h01000002, 0, 2, 32'h00002233, 0, 3'd1));
    tbl.push_back(mk(1, 3'd1, 32'h01000003, 32'h1234FF80, 3, 0, 0, 3'd0));
    tbl.push_back(mk(0, 3'd1, 32'h01000003, 0, 3, 32'hFFFFFF80, 0, 3'd4));
    tbl.push_back(mk(0, 3'd5, 32'h01000003, 0, 3, 32'h0000FF80, 0, 3'd4));
    tbl.push_back(mk(1, 3'd0, 32'h01000005, 32'hFFFFFFAB, 2, 0, 0, 3'd0));
    tbl.push_back(mk(0, 3'd4, 32'h01000005, 0, 2, 32'h000000AB, 0, 3'd4));
    tbl.push_back(mk(0, 3'd2, 32'h01000003, 0, 5, 32'h00ABFF80, 0, 3'd4));
    tbl.push_back(mk(0, 3'd2, 32'h01000002, 0, 5, 32'hABFF8033, 0, 3'd4));
    tbl.push_back(mk(0, 3'd1, 32'hFFFFFFFF, 0, 3, 32'hFFFFEF34, 0, 3'd4));
    tbl.push_back(mk(0, 3'd5, 32'hFFFFFFFF, 0, 3, 32'h0000EF34, 0, 3'd4));
    tbl.push_back(mk(1, 3'd2, 32'h01000008, 32'hCAFEF00D, 2, 0, 0, 3'd2));
    tbl.push_back(mk(0, 3'd2, 32'h01000009, 0, 5, 32'h00CAFEF0, 0, 3'd4));
`endif
    foreach (tbl[i]) run_vec(tbl[i], i);

`ifndef LSU_MISALIGNED_TRAP_EN
    // reset in the middle of a split store
    wlog.delete();
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd2;
    req_addr_i = 32'h01000001; req_wdata_i = 32'h5566A7B8;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_k2_we", 32'(mem_write_en_o), 32'd1);
    chk("mid_k2_addr", mem_addr_o, 32'h01000003);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_en", 32'({mem_read_en_o, mem_write_en_o}), 32'd0);
    chk("mid_rst_resp", 32'(resp_valid_o), 32'd0);
    chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    chk("mid_hold_resp", 32'(resp_valid_o), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_after_resp", 32'(resp_valid_o), 32'd0);
      chk("mid_after_ready", 32'(req_ready_o), 32'd1);
    end
    chk("mid_wcount", 32'(wlog.size()), 32'd2);
    w0 = (wlog.size() > 0) ? wlog[0] : 32'hFFFFFFFF;
    w1 = (wlog.size() > 1) ? wlog[1] : 32'hFFFFFFFF;
    chk("mid_w0", w0, 32'h01000001);
    chk("mid_w1", w1, 32'h01000002);
    chk("mid_m1", 32'(mem[1]), 32'hB8);
    chk("mid_m2", 32'(mem[2]), 32'hA7);
    chk("mid_m3", 32'(mem[3]), 32'h80);
    chk("mid_m4", 32'(mem[4]), 32'hFF);
    run_vec(mk(0, 3'd2, 32'h01000001, 0, 5, 32'hFF80A7B8, 0, 3'd4), 99);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator sitting between the pipeline memory stage and the byte-addressable data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Aligned accesses are issued to memory as a single access using the request's funct3.
- Misaligned halfword/word accesses are split into sequential byte accesses, load bytes are reassembled and sign-extended, and the pipeline gets a one-cycle response pulse.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width (fixed 32 for byte splitting)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
req_valid_i  input  1  request valid
req_ready_o  output  1  initiator can accept a request
req_we_i  input  1  1=store, 0=load
req_funct3_i  input  3  access size/sign (FUNCT3_* encodings)
req_addr_i  input  AWIDTH  byte address
req_wdata_i  input  DWIDTH  store data, right-aligned
resp_valid_o  output  1  one-cycle completion pulse
resp_rdata_o  output  DWIDTH  load result; 0 for stores
resp_err_o  output  1  misaligned trap flag (see Optional Feature)
mem_addr_o  output  AWIDTH  memory byte address
mem_data_o  output  DWIDTH  memory write data
mem_read_en_o  output  1  memory read enable
mem_write_en_o  output  1  memory write enable
mem_funct3_o  output  3  memory access size
mem_data_i  input  DWIDTH  memory read data (combinational)

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-low.
- Reset:
  - State is IDLE; req_ready_o=1.
  - resp_valid_o, resp_err_o, all mem_* outputs and resp_rdata_o are 0.
  - Latched request, counter and byte buffer are cleared.
- FSM states: IDLE, ACCESS, BYTES, RESP.
- IDLE:
  - req_ready_o=1; all mem enables are 0.
  - On req_valid_i && req_ready_o, latch we/funct3/addr/wdata.
  - Size: LB/LBU/SB=1 byte, LH/LHU/SH=2 bytes, all other encodings=4 bytes (word).
  - Misaligned means size 2 with addr[0]=1, or size 4 with addr[1:0]!=0.
  - Next state is ACCESS if aligned, BYTES if misaligned.
- ACCESS:
  - Drive mem_addr_o=addr, mem_funct3_o=funct3, mem_data_o=wdata.
  - Assert mem_read_en_o for loads, mem_write_en_o for stores.
  - On the closing edge, capture mem_data_i unchanged, since memory already extends.
  - Next state: RESP.
- BYTES:
  - 2-bit counter k runs from 0 to N-1.
  - Drive mem_addr_o=addr+k, wrapping modulo 2^AWIDTH.
  - mem_funct3_o=FUNCT3_LBU for loads, FUNCT3_SB for stores.
  - mem_data_o[7:0]=wdata byte k; upper bits 0.
  - Loads: buffer byte k = mem_data_i[7:0] at each edge.
  - After k=N-1, go to RESP.
- RESP:
  - resp_valid_o=1 for exactly one cycle; next state IDLE.
  - Split loads: LH sign-extends bit 15, LHU zero-extends, word is passed as assembled.
  - Stores: resp_rdata_o=0.
- Latency from accept edge to resp_valid_o: aligned 2 cycles; misaligned N+1 cycles.
- req_ready_o=0 in every non-IDLE state. The next request is accepted in IDLE the cycle after RESP, so peak rate is one request per 3 cycles.
- No response backpressure; the consumer must take the pulse.
- mem_* outputs are combinational from state and latched data. They never depend on req_* in the same cycle.
- Reset mid-operation:
  - Enables drop immediately, with no response.
  - Memory writes already completed stay committed; partial split stores are not rolled back.
- Store data held on req_wdata_i after acceptance is ignored; latched copy is used.

Optional Feature:
- Macro LSU_MISALIGNED_TRAP_EN.
- Defined:
  - Misaligned requests go IDLE->RESP with no memory access and no enables asserted.
  - resp_err_o=1 and resp_rdata_o=0 for the pulse.
  - Aligned behaviour is unchanged.
- Undefined: splitting as above; resp_err_o is tied 0.

Decomposition:
- FUNCT3_* constants stay in constants.svh.
- Add to constants.svh: lsu_state_t enum (IDLE, ACCESS, BYTES, RESP) and size localparams (1/2/4).
- One combinational sub-module, lsu_align_check: inputs funct3 and addr[1:0]; outputs byte count and misaligned flag.

Test Plan:
1. Aligned LW at 0x01000000, memory word 0xDEADBEEF -> one ACCESS cycle with mem_funct3_o=2 and read_en=1; resp_valid 2 cycles after accept; rdata=0xDEADBEEF.
2. SW 0x11223344 at 0x01000001 -> four SB cycles to 0x01000001..04 with data 0x44,0x33,0x22,0x11; resp_valid at cycle 5; rdata=0.
3. LH at 0x01000003, bytes 0x80 at 03 and 0xFF at 04 -> two LBU reads, rdata=0xFFFFFF80; LHU same address -> 0x0000FF80.
4. req_valid_i held high for two LW requests -> req_ready_o low through ACCESS and RESP; second request accepted the cycle after the first resp pulse.
5. rst low during k=2 of misaligned SW at 0x01000001 -> enables drop in the same cycle, no resp; only 0x01000001-02 written; req_ready_o=1 after release. Also LH at 0xFFFFFFFF -> byte accesses to 0xFFFFFFFF then 0x00000000.
6. With LSU_MISALIGNED_TRAP_EN, LW at 0x01000002 -> no enables; resp_valid and resp_err_o high 1 cycle after accept; aligned LW behaves as in test 1.
